// File: rtl/cobs_arb_pkg.sv
// Shared types and helpers for the COBS stream arbiter.
// Holds the arbiter state encoding, the byte width and the channel-ID helper.
// Pure declarations; no logic, so no latency or flow-control behaviour.
package cobs_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  // Channel ID byte placed in front of every packet from source idx.
  function automatic logic [BYTE_W-1:0] id_byte(input logic [BYTE_W-1:0] base,
                                                 input int unsigned idx);
    return base + BYTE_W'(idx);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker over N request lines.
// Zero latency: grant is a pure function of req_i and last_i.
// No flow control; the caller decides when to sample the grant.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] cand;

  // Search starting just after the previous winner, wrapping at N.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_i) + k) % N);
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/cobs_stream_arbiter.sv
// Packet-atomic round-robin mux of byte streams into one COBS raw-stream sink, with channel-ID header and length cap.
// One cycle from accepted source byte (or header) to m_*; two cycles of overhead per packet.
// Source ready follows the output slot; overlong packets are drained from the source with no output.
module cobs_stream_arbiter
  import cobs_arb_pkg::*;
#(
  parameter  int                 NUM_SOURCES = 2,
  parameter  int                 MAX_PKT_LEN = 254,
  parameter  logic [BYTE_W-1:0]  ID_BASE     = 8'h01,
  localparam int                 IW          = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BYTE_W*NUM_SOURCES-1:0] s_tdata,
  input  logic [NUM_SOURCES-1:0]        s_tvalid,
  output logic [NUM_SOURCES-1:0]        s_tready,
  input  logic [NUM_SOURCES-1:0]        s_tlast,
  output logic [BYTE_W-1:0]             m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          m_tuser,
  output logic [IW-1:0]                 grant_idx,
  output logic                          busy
);

  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BYTE_W-1:0] dat_q, dat_d;
  logic              vld_q, vld_d;
  logic              lst_q, lst_d;
  logic              usr_q, usr_d;

  logic              slot_free;
  logic [IW-1:0]     arb_idx;
  logic              arb_vld;
  logic [BYTE_W-1:0] sel_dat;
  logic              sel_vld;
  logic              sel_lst;

  rr_arbiter #(.N(NUM_SOURCES)) u_rr (
    .req_i     (s_tvalid),
    .last_i    (last_q),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  assign slot_free = !vld_q || m_tready;
  assign sel_dat   = s_tdata[BYTE_W*grant_q +: BYTE_W];
  assign sel_vld   = s_tvalid[grant_q];
  assign sel_lst   = s_tlast[grant_q];

  // Next-state, output slot loading and source ready for the granted stream.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    vld_d    = vld_q && !m_tready;
    lst_d    = lst_q;
    usr_d    = usr_q;
    s_tready = '0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d = arb_idx;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (slot_free) begin
          dat_d   = id_byte(ID_BASE, 32'(grant_q));
          vld_d   = 1'b1;
          lst_d   = 1'b0;
          usr_d   = 1'b0;
          cnt_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        s_tready[grant_q] = slot_free;
        if (slot_free && sel_vld) begin
          dat_d = sel_dat;
          vld_d = 1'b1;
          lst_d = sel_lst;
          usr_d = 1'b0;
          cnt_d = cnt_q + CW'(1);
          if (sel_lst) begin
            last_d  = grant_q;
            state_d = IDLE;
          end else if (cnt_q == CW'(MAX_PKT_LEN - 1)) begin
            // Limit hit without tlast: close the frame as bad, swallow the rest.
            lst_d   = 1'b1;
            usr_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        s_tready[grant_q] = 1'b1;
        if (sel_vld && sel_lst) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_SOURCES - 1);
      cnt_q   <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      lst_q   <= 1'b0;
      usr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      usr_q   <= usr_d;
    end
  end

  assign m_tdata   = dat_q;
  assign m_tvalid  = vld_q;
  assign m_tlast   = lst_q;
  assign m_tuser   = usr_q;
  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);

endmodule
